// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction-memory write port: packs LEN/data frames into words
// and holds the core in reset while loading. Optional trailing XOR byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [LEN_W-1:0]    words_loaded_q, words_loaded_d;
    logic                rx_ready_q, rx_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wd_q, mem_wd_d;
    logic                core_reset_q, core_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept;
    logic [LEN_W-1:0]    len_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    assign accept = rx_valid & rx_ready_q;
    assign len_n  = {rx_data, len_q[7:0]};

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            words_loaded_q <= '0;
            rx_ready_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wd_q       <= '0;
            core_reset_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            words_loaded_q <= words_loaded_d;
            rx_ready_q     <= rx_ready_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wd_q       <= mem_wd_d;
            core_reset_q   <= core_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q          <= chk_d;
`endif
        end
    end

    // Next state plus registered outputs decoded from the next state.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        words_loaded_d = words_loaded_q;
        core_reset_d   = core_reset_q;
        busy_d         = busy_q;
        done_d         = done_q;
        error_d        = error_q;
        rx_ready_d     = 1'b0;
        mem_we_d       = 1'b0;
        mem_addr_d     = '0;
        mem_wd_d       = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d          = chk_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) begin
                    state_d        = S_LEN0;
                    len_d          = '0;
                    byte_cnt_d     = '0;
                    words_loaded_d = '0;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    busy_d         = 1'b1;
                    core_reset_d   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d          = '0;
`endif
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d   = {8'h00, rx_data};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = len_n;
                    if (len_n == '0)
                        state_d = S_DONE;
                    else if (32'(len_n) > MAX_WORDS)
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ rx_data;
`endif
                    if (byte_cnt_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                words_loaded_d = words_loaded_q + 16'd1;
                if (words_loaded_d == len_q)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                else
                    state_d = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept)
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Session end: DONE releases the core, ERROR keeps it held.
        if (state_d != state_q) begin
            if (state_d == S_DONE) begin
                busy_d       = 1'b0;
                done_d       = 1'b1;
                core_reset_d = 1'b0;
            end else if (state_d == S_ERROR) begin
                busy_d  = 1'b0;
                error_d = 1'b1;
            end
        end

        rx_ready_d = state_d inside {S_LEN0, S_LEN1, S_DATA, S_CHK};
        if (state_d == S_WRITE) begin
            mem_we_d   = 1'b1;
            mem_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'({words_loaded_q, 2'b00});
            mem_wd_d   = word_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wd       = mem_wd_q;
    assign core_reset   = core_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: write scoreboard plus per-scenario status checks.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              Reset_n;
    logic              load_start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_wd_q[$];
    logic [31:0]       data_w[0:255];
    logic [7:0]        xacc;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_WORDS(256)) dut (
        .clk(clk), .Reset_n(Reset_n), .load_start(load_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: every mem_we cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (Reset_n && mem_we) begin
            logic [ADDR_W-1:0] ea;
            logic [31:0]       ed;
            checks++;
            wr_cnt++;
            if (exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h wd=%h", mem_addr, mem_wd);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_wd_q.pop_front();
                if (mem_addr !== ea || mem_wd !== ed || rx_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL write got addr=%h wd=%h rdy=%b want addr=%h wd=%h rdy=0",
                             mem_addr, mem_wd, rx_ready, ea, ed);
                end
            end
        end
    end

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  n   = 0;
        bit  acc = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = rx_ready;
            @(negedge clk);
            n++;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout byte=%h", b);
        end
    endtask

    task automatic send_word(input int i, input bit gaps);
        logic [31:0] w;
        w = data_w[i];
        exp_addr_q.push_back(ADDR_W'(4 * i));
        exp_wd_q.push_back(w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gaps);
            xacc ^= w[8*k +: 8];
        end
        checks++;
        if (mem_we !== 1'b1) begin
            failures++;
            $display("FAIL write_latency word=%0d mem_we=%b want 1", i, mem_we);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout busy=%b", busy);
        end
    endtask

    task automatic run_load(input int n, input bit gaps, input bit bad_chk);
        logic [15:0] len;
        len  = 16'(n);
        xacc = 8'h00;
        pulse_start();
        send_byte(len[7:0], gaps);
        send_byte(len[15:8], gaps);
        if (n > 0 && n <= 256) begin
            for (int i = 0; i < n; i++) send_word(i, gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(bad_chk ? 8'h00 : xacc, gaps);
`endif
        end
        wait_idle();
    endtask

    task automatic check_status(input string name, input logic [19:0] want);
        checks++;
        if ({busy, done, error, core_reset, words_loaded} !== want) begin
            failures++;
            $display("FAIL %s busy/done/err/crst/wl got=%b%b%b%b/%0d want=%b/%0d", name,
                     busy, done, error, core_reset, words_loaded, want[19:16], want[15:0]);
        end
    endtask

    task automatic check_writes(input string name, input int base, input int want);
        checks++;
        if (wr_cnt - base !== want || exp_addr_q.size() != 0) begin
            failures++;
            $display("FAIL %s writes got=%0d pending=%0d want=%0d", name, wr_cnt - base,
                     exp_addr_q.size(), want);
        end
    endtask

    task automatic set_prog();
        data_w[0] = 32'h0050_0013;
        data_w[1] = 32'h0010_0093;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        checks++;
        if ({rx_ready, mem_we, mem_addr, mem_wd, core_reset, busy, done, error, words_loaded} !== '0) begin
            failures++;
            $display("FAIL reset_state outputs not all zero");
        end
        pulse_start();
        check_status("start_sets_busy", {4'b1001, 16'd0});
        send_byte(8'h02, 1'b0);
        @(posedge clk);
        #3 Reset_n = 1'b0;
        #1;
        checks++;
        if ({rx_ready, mem_we, mem_addr, mem_wd, core_reset, busy, done, error, words_loaded} !== '0) begin
            failures++;
            $display("FAIL async_reset outputs not zero before clk edge rdy=%b crst=%b busy=%b",
                     rx_ready, core_reset, busy);
        end
        @(negedge clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_load();
        int base = wr_cnt;
        set_prog();
        run_load(2, 1'b0, 1'b0);
        check_status("load", {4'b0100, 16'd2});
        check_writes("load", base, 2);
    endtask

    task automatic test_backpressure();
        int base = wr_cnt;
        set_prog();
        run_load(2, 1'b1, 1'b0);
        check_status("backpressure", {4'b0100, 16'd2});
        check_writes("backpressure", base, 2);
    endtask

    task automatic test_boundaries();
        int base = wr_cnt;
        run_load(0, 1'b0, 1'b0);
        check_status("n_zero", {4'b0100, 16'd0});
        check_writes("n_zero", base, 0);
        base = wr_cnt;
        run_load(16'h0101, 1'b0, 1'b0);
        check_status("n_too_big", {4'b0011, 16'd0});
        check_writes("n_too_big", base, 0);
        for (int i = 0; i < 256; i++) data_w[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
        base = wr_cnt;
        run_load(256, 1'b0, 1'b0);
        check_status("n_max", {4'b0100, 16'd256});
        check_writes("n_max", base, 256);
    endtask

    task automatic test_abuse();
        int base = wr_cnt;
        set_prog();
        xacc = 8'h00;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_addr_q.push_back(ADDR_W'(0));
        exp_wd_q.push_back(data_w[0]);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) pulse_start();
            send_byte(data_w[0][8*k +: 8], 1'b0);
            xacc ^= data_w[0][8*k +: 8];
        end
        send_word(1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xacc, 1'b0);
`endif
        wait_idle();
        check_status("start_in_data", {4'b0100, 16'd2});
        check_writes("start_in_data", base, 2);

        base = wr_cnt;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(0, 1'b0);
        send_byte(data_w[1][7:0], 1'b0);
        @(negedge clk);
        #2 Reset_n = 1'b0;
        #1;
        check_status("mid_reset", {4'b0000, 16'd0});
        repeat (3) @(negedge clk);
        check_writes("mid_reset", base, 1);
        Reset_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int base = wr_cnt;
        set_prog();
        run_load(2, 1'b0, 1'b1);
        check_status("chk_bad", {4'b0011, 16'd2});
        check_writes("chk_bad", base, 2);
        base = wr_cnt;
        run_load(2, 1'b0, 1'b0);
        check_status("chk_good", {4'b0100, 16'd2});
        check_writes("chk_good", base, 2);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_backpressure();
        test_boundaries();
        test_abuse();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
